clk_time_set_ctrl: RTL

//  Button-driven time-set controller for the 24-hour ms clock core. It sequences
//  the core's load path: captures live time, steps the user through hour, minute
//  and second edits, then fires a single-cycle Timeset pulse with the new values.

---
 rtl/clk_time_pkg.sv | 21 ++
 rtl/clk_time_set_ctrl_if.sv | 29 ++
 rtl/clk_field_adj.sv | 40 ++++
 rtl/clk_time_set_ctrl.sv | 134 +++++++++++++
 4 files changed

// File: rtl/clk_time_pkg.sv
// Shared types and constants for the button-driven time-set controller.
package clk_time_pkg;

  localparam int unsigned HOUR_W      = 5;
  localparam int unsigned MS_W        = 6;
  localparam int unsigned MIN_SEC_MAX = 59;

  localparam logic [1:0] FIELD_NONE = 2'd0;
  localparam logic [1:0] FIELD_HOUR = 2'd1;
  localparam logic [1:0] FIELD_MIN  = 2'd2;
  localparam logic [1:0] FIELD_SEC  = 2'd3;

  typedef enum logic [2:0] {
    StRun,
    StSetH,
    StSetM,
    StSetS,
    StLoad
  } state_e;

endpackage

// File: rtl/clk_time_set_ctrl_if.sv
// Button, live-time and load-path signals between the front end, the controller and the core.
interface clk_time_set_ctrl_if;
  import clk_time_pkg::*;

  logic              mode_i;
  logic              inc_i;
  logic              dec_i;
  logic              cancel_i;
  logic [HOUR_W-1:0] hour_i;
  logic [MS_W-1:0]   min_i;
  logic [MS_W-1:0]   sec_i;
  logic              timeset_o;
  logic [HOUR_W-1:0] hourset_o;
  logic [MS_W-1:0]   minset_o;
  logic [MS_W-1:0]   secset_o;
  logic [1:0]        field_o;
  logic              busy_o;

  modport master (
    output mode_i, inc_i, dec_i, cancel_i, hour_i, min_i, sec_i,
    input  timeset_o, hourset_o, minset_o, secset_o, field_o, busy_o
  );

  modport slave (
    input  mode_i, inc_i, dec_i, cancel_i, hour_i, min_i, sec_i,
    output timeset_o, hourset_o, minset_o, secset_o, field_o, busy_o
  );

endinterface

// File: rtl/clk_field_adj.sv
// Wrap-around up/down field register; out-of-range load values are clamped to 0.
module clk_field_adj #(
  parameter int unsigned MAX = 59,
  parameter int unsigned W   = 6
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  input  logic         inc_i,
  input  logic         dec_i,
  output logic [W-1:0] val_o
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] val_q, val_d;

  always_comb begin
    val_d = val_q;
    if (load_i) begin
      val_d = (load_val_i > MaxVal) ? '0 : load_val_i;
    end else if (inc_i && !dec_i) begin
      val_d = (val_q == MaxVal) ? '0 : val_q + W'(1);
    end else if (dec_i && !inc_i) begin
      val_d = (val_q == '0) ? MaxVal : val_q - W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      val_q <= '0;
    end else begin
      val_q <= val_d;
    end
  end

  assign val_o = val_q;

endmodule

// File: rtl/clk_time_set_ctrl.sv
// Time-set sequencer: capture live time, edit hour/min/sec, then pulse the core load strobe.
module clk_time_set_ctrl
  import clk_time_pkg::*;
#(
  parameter int unsigned HOUR_MAX     = 23,
  parameter int unsigned IDLE_TIMEOUT = 10000,
  parameter int unsigned TMO_W        = 14
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  clk_time_set_ctrl_if.slave   bus_io
);

  localparam logic [TMO_W-1:0] TmoLast = TMO_W'(IDLE_TIMEOUT - 1);

  state_e           state_q, state_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;
  logic             timeset_q, busy_q;
  logic [1:0]       field_q, field_d;
  logic             capture;
  logic             h_inc, h_dec, m_inc, m_dec, s_inc, s_dec;
  logic             edit_state, adjust;

  assign edit_state = (state_q == StSetH) || (state_q == StSetM) || (state_q == StSetS);
  // Field adjust only when neither cancel nor mode claims the cycle.
  assign adjust     = edit_state && !bus_io.cancel_i && !bus_io.mode_i;

  always_comb begin
    state_d = state_q;
    capture = 1'b0;
    h_inc   = 1'b0;
    h_dec   = 1'b0;
    m_inc   = 1'b0;
    m_dec   = 1'b0;
    s_inc   = 1'b0;
    s_dec   = 1'b0;
    unique case (state_q)
      StRun: begin
        if (bus_io.mode_i) begin
          state_d = StSetH;
          capture = 1'b1;
        end
      end
      StSetH, StSetM, StSetS: begin
        if (bus_io.cancel_i) begin
          state_d = StRun;
        end else if (bus_io.mode_i) begin
          state_d = (state_q == StSetH) ? StSetM :
                    (state_q == StSetM) ? StSetS : StLoad;
        end else if (!bus_io.inc_i && !bus_io.dec_i && tmo_q == TmoLast) begin
          state_d = StRun;
        end
        h_inc = adjust && (state_q == StSetH) && bus_io.inc_i;
        h_dec = adjust && (state_q == StSetH) && bus_io.dec_i;
        m_inc = adjust && (state_q == StSetM) && bus_io.inc_i;
        m_dec = adjust && (state_q == StSetM) && bus_io.dec_i;
        s_inc = adjust && (state_q == StSetS) && bus_io.inc_i;
        s_dec = adjust && (state_q == StSetS) && bus_io.dec_i;
      end
      StLoad:  state_d = StRun;
      default: state_d = StRun;
    endcase
  end

  // Idle count runs only while staying in an edit state with no button activity.
  always_comb begin
    tmo_d = '0;
    if (edit_state && state_d == state_q &&
        !(bus_io.mode_i || bus_io.inc_i || bus_io.dec_i)) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_comb begin
    field_d = FIELD_NONE;
    unique case (state_d)
      StSetH:  field_d = FIELD_HOUR;
      StSetM:  field_d = FIELD_MIN;
      StSetS:  field_d = FIELD_SEC;
      default: field_d = FIELD_NONE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= StRun;
      tmo_q     <= '0;
      timeset_q <= 1'b0;
      field_q   <= FIELD_NONE;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tmo_q     <= tmo_d;
      timeset_q <= (state_d == StLoad);
      field_q   <= field_d;
      busy_q    <= (state_d != StRun);
    end
  end

  clk_field_adj #(.MAX(HOUR_MAX), .W(HOUR_W)) u_hour (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (capture),
    .load_val_i (bus_io.hour_i),
    .inc_i      (h_inc),
    .dec_i      (h_dec),
    .val_o      (bus_io.hourset_o)
  );

  clk_field_adj #(.MAX(MIN_SEC_MAX), .W(MS_W)) u_min (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (capture),
    .load_val_i (bus_io.min_i),
    .inc_i      (m_inc),
    .dec_i      (m_dec),
    .val_o      (bus_io.minset_o)
  );

  clk_field_adj #(.MAX(MIN_SEC_MAX), .W(MS_W)) u_sec (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .load_i     (capture),
    .load_val_i (bus_io.sec_i),
    .inc_i      (s_inc),
    .dec_i      (s_dec),
    .val_o      (bus_io.secset_o)
  );

  assign bus_io.timeset_o = timeset_q;
  assign bus_io.field_o   = field_q;
  assign bus_io.busy_o    = busy_q;

endmodule
